// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-index width, zero register, ALU control codes.
package pipe_pkg;

    localparam int unsigned RW       = 5;
    localparam int unsigned ZERO_REG = 0;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_AND = 4'b0001,
        ALU_XOR = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_OR  = 4'b0101,
        ALU_LUI = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SRA = 4'b1111
    } aluc_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass select: EXE result, then MEM result, else register-file value.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic [XLEN-1:0]  rf_val_i,
    input  logic [XLEN-1:0]  ex_result_i,
    input  logic [IDX_W-1:0] ex_rn_i,
    input  logic             ex_wreg_i,
    input  logic             ex_m2reg_i,
    input  logic [XLEN-1:0]  mem_result_i,
    input  logic [IDX_W-1:0] mem_rn_i,
    input  logic             mem_wreg_i,
    output logic [XLEN-1:0]  val_o
);

    logic ex_hit;
    logic mem_hit;

    // A load in EXE has no data yet; that case is covered by the stall logic.
    assign ex_hit  = ex_wreg_i & ~ex_m2reg_i & (ex_rn_i != IDX_W'(ZERO_REG)) & (ex_rn_i == idx_i);
    assign mem_hit = mem_wreg_i & (mem_rn_i != IDX_W'(ZERO_REG)) & (mem_rn_i == idx_i);

    always_comb begin
        val_o = rf_val_i;
        if (mem_hit) val_o = mem_result_i;
        if (ex_hit)  val_o = ex_result_i;
    end

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with operand forwarding and load-use stall detection.
module id_exe_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RW   = pipe_pkg::RW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_ra,
    input  logic [XLEN-1:0] id_rb,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_sa,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [RW-1:0]   id_rn,
    input  logic [3:0]      id_aluc,
    input  logic            id_aluimm,
    input  logic            id_shift,
    input  logic            id_wreg,
    input  logic            id_m2reg,
    input  logic            id_wmem,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RW-1:0]   mem_rn,
    input  logic            mem_wreg,
    input  logic            flush,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_aluc,
    output logic [RW-1:0]   ex_rn,
    output logic            ex_wreg,
    output logic            ex_m2reg,
    output logic            ex_wmem,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_store_data,
    output logic            stall
);

    logic [XLEN-1:0] ex_a_q, ex_a_d;
    logic [XLEN-1:0] ex_b_q, ex_b_d;
    logic [XLEN-1:0] ex_sd_q, ex_sd_d;
    logic [3:0]      ex_aluc_q, ex_aluc_d;
    logic [RW-1:0]   ex_rn_q, ex_rn_d;
    logic            ex_wreg_q, ex_wreg_d;
    logic            ex_m2reg_q, ex_m2reg_d;
    logic            ex_wmem_q, ex_wmem_d;
    logic            ex_valid_q, ex_valid_d;

    logic [XLEN-1:0] fa;
    logic [XLEN-1:0] fb;
    logic            hazard;

    fwd_mux #(.XLEN(XLEN), .IDX_W(RW)) u_fwd_rs (
        .idx_i        (id_rs),
        .rf_val_i     (id_ra),
        .ex_result_i  (ex_result),
        .ex_rn_i      (ex_rn_q),
        .ex_wreg_i    (ex_wreg_q),
        .ex_m2reg_i   (ex_m2reg_q),
        .mem_result_i (mem_result),
        .mem_rn_i     (mem_rn),
        .mem_wreg_i   (mem_wreg),
        .val_o        (fa)
    );

    fwd_mux #(.XLEN(XLEN), .IDX_W(RW)) u_fwd_rt (
        .idx_i        (id_rt),
        .rf_val_i     (id_rb),
        .ex_result_i  (ex_result),
        .ex_rn_i      (ex_rn_q),
        .ex_wreg_i    (ex_wreg_q),
        .ex_m2reg_i   (ex_m2reg_q),
        .mem_result_i (mem_result),
        .mem_rn_i     (mem_rn),
        .mem_wreg_i   (mem_wreg),
        .val_o        (fb)
    );

    assign hazard = ex_valid_q & ex_wreg_q & ex_m2reg_q & (ex_rn_q != RW'(pipe_pkg::ZERO_REG)) &
                    ((id_use_rs & (ex_rn_q == id_rs)) | (id_use_rt & (ex_rn_q == id_rt)));
    // Gated by rst so stall stays low before the first reset edge clears the register.
    assign stall  = hazard & id_valid & ~flush & ~rst;

    always_comb begin
        ex_a_d     = '0;
        ex_b_d     = '0;
        ex_sd_d    = '0;
        ex_aluc_d  = pipe_pkg::ALU_ADD;
        ex_rn_d    = '0;
        ex_wreg_d  = 1'b0;
        ex_m2reg_d = 1'b0;
        ex_wmem_d  = 1'b0;
        ex_valid_d = 1'b0;
        if (id_valid && !flush && !stall) begin
            ex_a_d     = id_shift ? XLEN'(id_sa) : fa;
            ex_b_d     = id_aluimm ? id_imm : fb;
            ex_sd_d    = fb;
            ex_aluc_d  = id_aluc;
            ex_rn_d    = id_rn;
            ex_wreg_d  = id_wreg;
            ex_m2reg_d = id_m2reg;
            ex_wmem_d  = id_wmem;
            ex_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_sd_q    <= '0;
            ex_aluc_q  <= pipe_pkg::ALU_ADD;
            ex_rn_q    <= '0;
            ex_wreg_q  <= 1'b0;
            ex_m2reg_q <= 1'b0;
            ex_wmem_q  <= 1'b0;
            ex_valid_q <= 1'b0;
        end else begin
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_sd_q    <= ex_sd_d;
            ex_aluc_q  <= ex_aluc_d;
            ex_rn_q    <= ex_rn_d;
            ex_wreg_q  <= ex_wreg_d;
            ex_m2reg_q <= ex_m2reg_d;
            ex_wmem_q  <= ex_wmem_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign ex_a          = ex_a_q;
    assign ex_b          = ex_b_q;
    assign ex_store_data = ex_sd_q;
    assign ex_aluc       = ex_aluc_q;
    assign ex_rn         = ex_rn_q;
    assign ex_wreg       = ex_wreg_q;
    assign ex_m2reg      = ex_m2reg_q;
    assign ex_wmem       = ex_wmem_q;
    assign ex_valid      = ex_valid_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Bench for id_exe_stage: directed forwarding/hazard scenarios plus a randomized run against a reference model.
module tb_id_exe_stage;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [XLEN-1:0] id_ra, id_rb, id_imm;
    logic [4:0]      id_sa;
    logic [RW-1:0]   id_rs, id_rt, id_rn;
    logic            id_use_rs, id_use_rt;
    logic [3:0]      id_aluc;
    logic            id_aluimm, id_shift, id_wreg, id_m2reg, id_wmem;
    logic [XLEN-1:0] ex_result, mem_result;
    logic [RW-1:0]   mem_rn;
    logic            mem_wreg;
    logic            flush;
    logic [XLEN-1:0] ex_a, ex_b, ex_store_data;
    logic [3:0]      ex_aluc;
    logic [RW-1:0]   ex_rn;
    logic            ex_wreg, ex_m2reg, ex_wmem, ex_valid;
    logic            stall;

    int checks   = 0;
    int failures = 0;

    // Architectural contents of the ID/EXE latch as the bench expects it.
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] sd;
        logic [3:0]      aluc;
        logic [RW-1:0]   rn;
        logic            wreg;
        logic            m2reg;
        logic            wmem;
        logic            valid;
    } latch_t;

    latch_t mdl;

    id_exe_stage #(.XLEN(XLEN), .RW(RW)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_ra         (id_ra),
        .id_rb         (id_rb),
        .id_imm        (id_imm),
        .id_sa         (id_sa),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_rn         (id_rn),
        .id_aluc       (id_aluc),
        .id_aluimm     (id_aluimm),
        .id_shift      (id_shift),
        .id_wreg       (id_wreg),
        .id_m2reg      (id_m2reg),
        .id_wmem       (id_wmem),
        .ex_result     (ex_result),
        .mem_result    (mem_result),
        .mem_rn        (mem_rn),
        .mem_wreg      (mem_wreg),
        .flush         (flush),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_aluc       (ex_aluc),
        .ex_rn         (ex_rn),
        .ex_wreg       (ex_wreg),
        .ex_m2reg      (ex_m2reg),
        .ex_wmem       (ex_wmem),
        .ex_valid      (ex_valid),
        .ex_store_data (ex_store_data),
        .stall         (stall)
    );

    always #5 clk = ~clk;

    function automatic latch_t observed();
        return {ex_a, ex_b, ex_store_data, ex_aluc, ex_rn, ex_wreg, ex_m2reg, ex_wmem, ex_valid};
    endfunction

    // Newest producer wins; register 0 always reads as the register-file value.
    function automatic logic [XLEN-1:0] bypass(input logic [RW-1:0] idx, input logic [XLEN-1:0] rf);
        if (idx == 0) return rf;
        if (mdl.wreg && !mdl.m2reg && mdl.rn == idx) return ex_result;
        if (mem_wreg && mem_rn == idx) return mem_result;
        return rf;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_ra = '0; id_rb = '0; id_imm = '0; id_sa = '0;
        id_rs = '0; id_rt = '0; id_rn = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_aluc = '0; id_aluimm = 1'b0; id_shift = 1'b0;
        id_wreg = 1'b0; id_m2reg = 1'b0; id_wmem = 1'b0;
        ex_result = '0; mem_result = '0; mem_rn = '0; mem_wreg = 1'b0;
    endtask

    // Issue a register-writing instruction (load if is_load) into EXE.
    task automatic issue_producer(input logic [RW-1:0] rn, input logic is_load);
        clear_inputs();
        id_valid = 1'b1; id_rn = rn; id_wreg = 1'b1; id_m2reg = is_load;
        id_rs = 5'd30; id_rt = 5'd31;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1; id_valid = 1'b1; id_rn = 5'd7; id_wreg = 1'b1; id_wmem = 1'b1;
        id_ra = 32'hDEAD_BEEF; id_aluc = 4'b1111;
        tick();
        tick();
        checks++;
        if (observed() !== latch_t'(0)) begin
            failures++; $display("FAIL reset_regs got %h exp 0", observed());
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL reset_stall got %b exp 0", stall);
        end
        clear_inputs();
        id_valid = 1'b1; id_use_rs = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL post_reset_stall got %b exp 0", stall);
        end
        tick();
    endtask

    task automatic test_fwd_exe();
        issue_producer(5'd3, 1'b0);
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1; id_ra = 32'h99; id_rn = 5'd5; id_wreg = 1'b1;
        ex_result = 32'h10;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL fwd_exe_stall got %b exp 0", stall);
        end
        tick();
        checks++;
        if (ex_a !== 32'h10) begin
            failures++; $display("FAIL fwd_exe_a got %h exp 00000010", ex_a);
        end
        checks++;
        if (ex_valid !== 1'b1 || ex_rn !== 5'd5) begin
            failures++; $display("FAIL fwd_exe_ctrl got valid=%b rn=%0d exp valid=1 rn=5", ex_valid, ex_rn);
        end
    endtask

    task automatic test_fwd_priority();
        issue_producer(5'd3, 1'b0);
        clear_inputs();
        id_valid = 1'b1; id_rt = 5'd3; id_use_rt = 1'b1; id_rb = 32'h77; id_rn = 5'd3; id_wreg = 1'b0;
        ex_result = 32'h10; mem_result = 32'h20; mem_rn = 5'd3; mem_wreg = 1'b1;
        tick();
        checks++;
        if (ex_b !== 32'h10 || ex_store_data !== 32'h10) begin
            failures++; $display("FAIL fwd_prio_exe got b=%h sd=%h exp 00000010", ex_b, ex_store_data);
        end
        // The instruction now in EXE has wreg=0, so MEM must supply r3.
        tick();
        checks++;
        if (ex_b !== 32'h20 || ex_store_data !== 32'h20) begin
            failures++; $display("FAIL fwd_prio_mem got b=%h sd=%h exp 00000020", ex_b, ex_store_data);
        end
    endtask

    task automatic test_load_use();
        issue_producer(5'd4, 1'b1);
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd4; id_use_rs = 1'b1; id_ra = 32'h99; id_rn = 5'd6; id_wreg = 1'b1;
        ex_result = 32'hAB;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL load_use_stall got %b exp 1", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_a !== 32'h0 || ex_wreg !== 1'b0) begin
            failures++; $display("FAIL load_use_bubble got valid=%b a=%h wreg=%b exp 0", ex_valid, ex_a, ex_wreg);
        end
        mem_rn = 5'd4; mem_wreg = 1'b1; mem_result = 32'h55;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL load_use_release got %b exp 0", stall);
        end
        tick();
        checks++;
        if (ex_a !== 32'h55 || ex_valid !== 1'b1) begin
            failures++; $display("FAIL load_use_fwd got a=%h valid=%b exp a=00000055 valid=1", ex_a, ex_valid);
        end
    endtask

    task automatic test_zero_reg();
        issue_producer(5'd0, 1'b0);
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd0; id_use_rs = 1'b1; id_ra = 32'h0;
        id_rn = 5'd0; id_wreg = 1'b1; id_m2reg = 1'b1;
        ex_result = 32'hFF;
        tick();
        checks++;
        if (ex_a !== 32'h0) begin
            failures++; $display("FAIL zero_fwd got %h exp 0", ex_a);
        end
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b1; id_use_rt = 1'b1; ex_result = 32'hFF;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL zero_load_stall got %b exp 0", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_a !== 32'h0) begin
            failures++; $display("FAIL zero_load_capture got valid=%b a=%h exp valid=1 a=0", ex_valid, ex_a);
        end
    endtask

    task automatic test_flush_and_reset();
        issue_producer(5'd4, 1'b1);
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd4; id_use_rs = 1'b1; id_rn = 5'd9; id_wreg = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL flush_stall got %b exp 0", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_wreg !== 1'b0) begin
            failures++; $display("FAIL flush_bubble got valid=%b wreg=%b exp 0", ex_valid, ex_wreg);
        end
        issue_producer(5'd4, 1'b1);
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd4; id_use_rs = 1'b1; id_rn = 5'd9; id_wreg = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++; $display("FAIL pre_reset_stall got %b exp 1", stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL reset_mid_stall got %b exp 0", stall);
        end
        tick();
        checks++;
        if (observed() !== latch_t'(0)) begin
            failures++; $display("FAIL reset_mid_stall_regs got %h exp 0", observed());
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_rn !== 5'd9) begin
            failures++; $display("FAIL after_reset_capture got valid=%b rn=%0d exp valid=1 rn=9", ex_valid, ex_rn);
        end
    endtask

    task automatic test_shift_and_idle();
        clear_inputs();
        id_valid = 1'b1; id_sa = 5'd5; id_shift = 1'b1; id_aluimm = 1'b1; id_imm = 32'h1234;
        id_aluc = 4'b0011; id_rs = 5'd9; id_ra = 32'h77; id_rn = 5'd2; id_wreg = 1'b1;
        tick();
        checks++;
        if (ex_a !== 32'd5 || ex_b !== 32'h1234 || ex_aluc !== 4'b0011) begin
            failures++; $display("FAIL shift_capture got a=%h b=%h aluc=%b exp a=5 b=1234 aluc=0011", ex_a, ex_b, ex_aluc);
        end
        id_valid = 1'b0;
        tick();
        checks++;
        if (observed() !== latch_t'(0)) begin
            failures++; $display("FAIL idle_bubble got %h exp 0", observed());
        end
    endtask

    task automatic test_random();
        latch_t nxt;
        logic   exp_stall;
        logic [XLEN-1:0] fa, fb;
        clear_inputs();
        rst = 1'b1;
        tick();
        mdl = '0;
        for (int i = 0; i < 600; i++) begin
            id_valid  = ($urandom_range(0, 7) != 0);
            id_ra     = $urandom; id_rb = $urandom; id_imm = $urandom;
            id_sa     = 5'($urandom);
            id_rs     = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_rn     = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            id_aluc   = 4'($urandom);
            id_aluimm = 1'($urandom); id_shift = ($urandom_range(0, 3) == 0);
            id_wreg   = 1'($urandom); id_m2reg = ($urandom_range(0, 2) == 0); id_wmem = 1'($urandom);
            ex_result = $urandom; mem_result = $urandom;
            mem_rn    = 5'($urandom_range(0, 3)); mem_wreg = 1'($urandom);
            flush     = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 59) == 0);
            #1;
            exp_stall = !rst && id_valid && !flush && mdl.valid && mdl.wreg && mdl.m2reg && mdl.rn != 0 &&
                        ((id_use_rs && mdl.rn == id_rs) || (id_use_rt && mdl.rn == id_rt));
            checks++;
            if (stall !== exp_stall) begin
                failures++; $display("FAIL rand_stall[%0d] got %b exp %b", i, stall, exp_stall);
            end
            nxt = '0;
            if (!rst && !flush && !exp_stall && id_valid) begin
                fa        = bypass(id_rs, id_ra);
                fb        = bypass(id_rt, id_rb);
                nxt.a     = id_shift ? {27'b0, id_sa} : fa;
                nxt.b     = id_aluimm ? id_imm : fb;
                nxt.sd    = fb;
                nxt.aluc  = id_aluc;
                nxt.rn    = id_rn;
                nxt.wreg  = id_wreg;
                nxt.m2reg = id_m2reg;
                nxt.wmem  = id_wmem;
                nxt.valid = 1'b1;
            end
            tick();
            mdl = nxt;
            checks++;
            if (observed() !== mdl) begin
                failures++; $display("FAIL rand_regs[%0d] got %h exp %h", i, observed(), mdl);
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fwd_exe();
        test_fwd_priority();
        test_load_use();
        test_zero_reg();
        test_flush_and_reset();
        test_shift_and_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
